// File: rtl/pu_msp430_dmem_arbiter_if.sv
// Bundles the CPU port, the DMA/debug port and the RAM pins of the DMEM arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/RAM view.
//   cpu_*/dma_* : req, we[1:0], addr, din in; gnt, rvalid, dout out
//   ram_*       : cen, wen[1:0] (active-low), addr, din out; dout in
interface pu_msp430_dmem_arbiter_if #(
    parameter int unsigned ADDR_MSB = 9
);
    localparam int unsigned AW = ADDR_MSB + 1;

    logic          cpu_req;
    logic [1:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_din;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [15:0]   cpu_dout;

    logic          dma_req;
    logic [1:0]    dma_we;
    logic [AW-1:0] dma_addr;
    logic [15:0]   dma_din;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [15:0]   dma_dout;

    logic          ram_cen;
    logic [1:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic [15:0]   ram_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  dma_req, dma_we, dma_addr, dma_din,
        input  ram_dout,
        output cpu_gnt, cpu_rvalid, cpu_dout,
        output dma_gnt, dma_rvalid, dma_dout,
        output ram_cen, ram_wen, ram_addr, ram_din
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output dma_req, dma_we, dma_addr, dma_din,
        output ram_dout,
        input  cpu_gnt, cpu_rvalid, cpu_dout,
        input  dma_gnt, dma_rvalid, dma_dout,
        input  ram_cen, ram_wen, ram_addr, ram_din
    );
endinterface

// File: rtl/pu_msp430_dmem_arbiter.sv
// Shares the single-port DMEM RAM between the CPU data bus and the DMA/debug bus.
// The CPU has fixed priority. A saturating wait counter lets a starved DMA request win.
// Read data returns one cycle after grant and is held per port between reads.
//   mclk    : clock
//   puc_rst : synchronous active-high reset
//   bus     : CPU port, DMA port and RAM pins (slave modport)
module pu_msp430_dmem_arbiter #(
    parameter int unsigned ADDR_MSB = 9,
    parameter int unsigned MAX_WAIT = 4    // legal 1..15
) (
    input  logic                          mclk,
    input  logic                          puc_rst,
    pu_msp430_dmem_arbiter_if.slave       bus
);
    localparam int unsigned AW = ADDR_MSB + 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;
    logic          starve;
    logic          cpu_gnt_c;
    logic          dma_gnt_c;
    logic          ram_cen_c;
    logic [1:0]    ram_wen_c;
    logic [AW-1:0] ram_addr_c;
    logic [15:0]   ram_din_c;
    logic          rd_cpu;
    logic          rd_dma;
    logic [15:0]   hold_cpu;
    logic [15:0]   hold_dma;

    assign starve = (wait_cnt == WAIT_LIM);

    // Grant decision: DMA wins when starved or when the CPU is idle.
    always_comb begin
        cpu_gnt_c = 1'b0;
        dma_gnt_c = 1'b0;
        if (!puc_rst) begin
            if (bus.dma_req && (starve || !bus.cpu_req)) begin
                dma_gnt_c = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt_c = 1'b1;
            end
        end
    end

    // RAM mux: idle bus parks at zero with the RAM deselected.
    always_comb begin
        ram_cen_c  = 1'b1;
        ram_wen_c  = 2'b11;
        ram_addr_c = '0;
        ram_din_c  = '0;
        if (dma_gnt_c) begin
            ram_cen_c  = 1'b0;
            ram_wen_c  = ~bus.dma_we;
            ram_addr_c = bus.dma_addr;
            ram_din_c  = bus.dma_din;
        end else if (cpu_gnt_c) begin
            ram_cen_c  = 1'b0;
            ram_wen_c  = ~bus.cpu_we;
            ram_addr_c = bus.cpu_addr;
            ram_din_c  = bus.cpu_din;
        end
    end

    // Wait counter and read-return pipeline.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wait_cnt <= '0;
            rd_cpu   <= 1'b0;
            rd_dma   <= 1'b0;
            hold_cpu <= '0;
            hold_dma <= '0;
        end else begin
            if (dma_gnt_c || !bus.dma_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt < WAIT_LIM) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            rd_cpu <= cpu_gnt_c && (bus.cpu_we == 2'b00);
            rd_dma <= dma_gnt_c && (bus.dma_we == 2'b00);
            if (rd_cpu) begin
                hold_cpu <= bus.ram_dout;
            end
            if (rd_dma) begin
                hold_dma <= bus.ram_dout;
            end
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_c;
    assign bus.dma_gnt    = dma_gnt_c;
    assign bus.ram_cen    = ram_cen_c;
    assign bus.ram_wen    = ram_wen_c;
    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_din    = ram_din_c;

    // A read still in flight when reset arrives is dropped and the outputs read as zero.
    assign bus.cpu_rvalid = rd_cpu && !puc_rst;
    assign bus.dma_rvalid = rd_dma && !puc_rst;
    assign bus.cpu_dout   = puc_rst ? 16'h0000 : (rd_cpu ? bus.ram_dout : hold_cpu);
    assign bus.dma_dout   = puc_rst ? 16'h0000 : (rd_dma ? bus.ram_dout : hold_dma);
endmodule

// File: tb/tb_pu_msp430_dmem_arbiter.sv
// Scoreboard bench for the DMEM arbiter with a behavioural single-port RAM behind it.
module tb_pu_msp430_dmem_arbiter;
    logic mclk;
    logic puc_rst;
    int   checks;
    int   failures;
    int   cyc;

    typedef struct {
        logic [15:0] data;
        int          stamp;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dma_q[$];

    pu_msp430_dmem_arbiter_if #(.ADDR_MSB(9)) bus ();

    pu_msp430_dmem_arbiter #(.ADDR_MSB(9), .MAX_WAIT(4)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    // Behavioural RAM: byte writes, read data one cycle after the access.
    logic [15:0] mem [0:1023];
    always @(posedge mclk) begin
        if (!bus.ram_cen) begin
            if (!bus.ram_wen[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
            if (!bus.ram_wen[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
            if (bus.ram_wen == 2'b11) bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected read data whenever a port presents rvalid.
    logic [15:0] hold_cpu_exp;
    logic [15:0] hold_dma_exp;
    always @(negedge mclk) begin
        exp_t e;
        if (puc_rst) begin
            chk("rst_cpu_rvalid", 16'(bus.cpu_rvalid), 16'h0);
            chk("rst_dma_rvalid", 16'(bus.dma_rvalid), 16'h0);
            chk("rst_cpu_dout", bus.cpu_dout, 16'h0000);
            chk("rst_dma_dout", bus.dma_dout, 16'h0000);
            hold_cpu_exp = 16'h0000;
            hold_dma_exp = 16'h0000;
        end else begin
            if (bus.cpu_rvalid) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_spurious_rvalid", 16'h1, 16'h0);
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_rdata", bus.cpu_dout, e.data);
                    hold_cpu_exp = e.data;
                end
            end else begin
                if (cpu_q.size() != 0 && cpu_q[0].stamp < cyc) begin
                    e = cpu_q.pop_front();
                    chk("cpu_missing_rvalid", 16'h0, 16'h1);
                end
                chk("cpu_dout_hold", bus.cpu_dout, hold_cpu_exp);
            end
            if (bus.dma_rvalid) begin
                if (dma_q.size() == 0) begin
                    chk("dma_spurious_rvalid", 16'h1, 16'h0);
                end else begin
                    e = dma_q.pop_front();
                    chk("dma_rdata", bus.dma_dout, e.data);
                    hold_dma_exp = e.data;
                end
            end else begin
                if (dma_q.size() != 0 && dma_q[0].stamp < cyc) begin
                    e = dma_q.pop_front();
                    chk("dma_missing_rvalid", 16'h0, 16'h1);
                end
                chk("dma_dout_hold", bus.dma_dout, hold_dma_exp);
            end
        end
    end

    // One bus cycle: drive at posedge+1, check grants/RAM drive at negedge, push reads.
    task automatic step(input logic rst,
                        input logic creq, input logic [1:0] cwe, input logic [9:0] caddr,
                        input logic [15:0] cdin,
                        input logic dreq, input logic [1:0] dwe, input logic [9:0] daddr,
                        input logic [15:0] ddin,
                        input logic ecg, input logic edg, input logic push,
                        input logic [15:0] cexp, input logic [15:0] dexp);
        logic [9:0] eaddr;
        puc_rst      = rst;
        bus.cpu_req  = creq;
        bus.cpu_we   = cwe;
        bus.cpu_addr = caddr;
        bus.cpu_din  = cdin;
        bus.dma_req  = dreq;
        bus.dma_we   = dwe;
        bus.dma_addr = daddr;
        bus.dma_din  = ddin;
        @(negedge mclk);
        eaddr = ecg ? caddr : (edg ? daddr : 10'h000);
        chk("cpu_gnt", 16'(bus.cpu_gnt), 16'(ecg));
        chk("dma_gnt", 16'(bus.dma_gnt), 16'(edg));
        chk("ram_cen", 16'(bus.ram_cen), 16'(!(ecg || edg)));
        chk("ram_addr", 16'(bus.ram_addr), 16'(eaddr));
        if (push && ecg && cwe == 2'b00) cpu_q.push_back('{data: cexp, stamp: cyc});
        if (push && edg && dwe == 2'b00) dma_q.push_back('{data: dexp, stamp: cyc});
        @(posedge mclk);
        #1;
    endtask

    task automatic cpu_op(input logic [1:0] we, input logic [9:0] a, input logic [15:0] d,
                          input logic [15:0] exp);
        step(1'b0, 1'b1, we, a, d, 1'b0, 2'b00, 10'h0, 16'h0, 1'b1, 1'b0, 1'b1, exp, 16'h0);
    endtask

    task automatic dma_op(input logic [1:0] we, input logic [9:0] a, input logic [15:0] d,
                          input logic [15:0] exp);
        step(1'b0, 1'b0, 2'b00, 10'h0, 16'h0, 1'b1, we, a, d, 1'b0, 1'b1, 1'b1, 16'h0, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 2'b00, 10'h0, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        hold_cpu_exp = 16'h0000;
        hold_dma_exp = 16'h0000;
        bus.ram_dout = 16'h0000;

        // Reset with both requests asserted.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b00, 10'h010, 16'h0, 1'b1, 2'b00, 10'h020, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(1);

        // CPU write then read back, followed by hold cycles.
        cpu_op(2'b11, 10'h010, 16'hA55A, 16'h0);
        cpu_op(2'b00, 10'h010, 16'h0, 16'hA55A);
        idle(2);

        // Byte writes.
        cpu_op(2'b11, 10'h020, 16'h1234, 16'h0);
        cpu_op(2'b01, 10'h020, 16'hFFCD, 16'h0);
        cpu_op(2'b00, 10'h020, 16'h0, 16'h12CD);
        cpu_op(2'b10, 10'h020, 16'hEFFF, 16'h0);
        cpu_op(2'b00, 10'h020, 16'h0, 16'hEFCD);
        idle(1);

        // Continuous contention: DMA wins every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            logic dg;
            dg = (i == 4) || (i == 9);
            step(1'b0, 1'b1, 2'b11, 10'h030, 16'(i), 1'b1, 2'b11, 10'h031, 16'h0100,
                 !dg, dg, 1'b0, 16'h0, 16'h0);
        end
        idle(1);

        // Interleaved reads.
        cpu_op(2'b11, 10'h040, 16'h1111, 16'h0);
        dma_op(2'b11, 10'h041, 16'h2222, 16'h0);
        cpu_op(2'b00, 10'h040, 16'h0, 16'h1111);
        dma_op(2'b00, 10'h041, 16'h0, 16'h2222);
        idle(2);

        // Simultaneous reads: CPU first, DMA retries the next cycle.
        step(1'b0, 1'b1, 2'b00, 10'h020, 16'h0, 1'b1, 2'b00, 10'h010, 16'h0,
             1'b1, 1'b0, 1'b1, 16'hEFCD, 16'h0);
        dma_op(2'b00, 10'h010, 16'h0, 16'hA55A);
        idle(2);

        // Reset mid-read: the granted read is dropped.
        step(1'b0, 1'b1, 2'b00, 10'h040, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0,
             1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 2'b00, 10'h0, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0,
             1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(3);

        chk("cpu_queue_empty", 16'(cpu_q.size()), 16'h0);
        chk("dma_queue_empty", 16'(dma_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
